// File: rtl/mic3_receiver.sv
// Pmod MIC3 (ADCS7476) receiver: periodic SPI conversions at a fixed rate,
// 16-bit frame capture, offset-binary and two's-complement 12-bit samples.
module mic3_receiver #(
    parameter int CLK_DIV       = 13,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mic_miso,
    output logic        mic_sclk,
    output logic        mic_cs_n,
    output logic [11:0] sample,
    output logic [11:0] pcm,
    output logic        sample_valid,
    output logic        frame_err
);

    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int HW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [PW-1:0] per_q, per_d;
    logic [HW-1:0] half_q, half_d;
    logic [4:0]    edges_q, edges_d;
    logic [15:0]   shift_q, shift_d;
    logic          sclk_q, sclk_d;
    logic          cs_n_q, cs_n_d;
    logic [11:0]   sample_q, sample_d;
    logic [11:0]   pcm_q, pcm_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          start;

    assign start = (per_q == '0) && enable && (state_q == IDLE);

    // Free-running sample-period counter, independent of enable
    always_comb begin
        per_d = per_q + 1'b1;
        if (per_q == PW'(SAMPLE_PERIOD - 1)) begin
            per_d = '0;
        end
    end

    // Conversion sequencing: SCLK generation, edge counting, MISO shifting
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        edges_d = edges_q;
        shift_d = shift_q;
        sclk_d  = 1'b1;
        unique case (state_q)
            IDLE: begin
                half_d  = '0;
                edges_d = '0;
                if (start) begin
                    state_d = CONV;
                end
            end
            CONV: begin
                sclk_d = sclk_q;
                if (half_q == HW'(CLK_DIV - 1)) begin
                    half_d = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        shift_d = {shift_q[14:0], sync2_q};
                        edges_d = edges_q + 5'd1;
                        if (edges_q == 5'd15) begin
                            state_d = DONE;
                        end
                    end
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs looked ahead from the next state
    always_comb begin
        cs_n_d   = (state_d != CONV);
        valid_d  = (state_d == DONE);
        sample_d = sample_q;
        pcm_d    = pcm_q;
        err_d    = err_q;
        if (valid_d) begin
            sample_d = shift_d[11:0];
            pcm_d    = {~shift_d[11], shift_d[10:0]};
            err_d    = |shift_d[15:12];
        end
    end

    // State, counters, synchronizer and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            per_q    <= '0;
            half_q   <= '0;
            edges_q  <= '0;
            shift_q  <= '0;
            sclk_q   <= 1'b1;
            cs_n_q   <= 1'b1;
            sample_q <= '0;
            pcm_q    <= 12'h800;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= mic_miso;
            sync2_q  <= sync1_q;
            per_q    <= per_d;
            half_q   <= half_d;
            edges_q  <= edges_d;
            shift_q  <= shift_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
            sample_q <= sample_d;
            pcm_q    <= pcm_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign mic_sclk     = sclk_q;
    assign mic_cs_n     = cs_n_q;
    assign sample       = sample_q;
    assign pcm          = pcm_q;
    assign sample_valid = valid_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_mic3_receiver.sv
// Bench for mic3_receiver: ADC models, frame monitors and a
// behavioural sample model; default and fast parameter sets.
module tb_mic3_receiver;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] m_sample(input logic [15:0] f);
        return f[11:0];
    endfunction

    function automatic logic [11:0] m_pcm(input logic [15:0] f);
        int v;
        v = int'(f[11:0]) - 2048;
        if (v < 0) v = v + 4096;
        return 12'(v);
    endfunction

    function automatic logic m_err(input logic [15:0] f);
        return (f >> 12) != 16'd0;
    endfunction

    // ---------------- DUT A: default parameters ----------------
    logic        rst_a, en_a, miso_a = 1'b0;
    logic        sclk_a, csn_a, valid_a, err_a;
    logic [11:0] sample_a, pcm_a;

    mic3_receiver dut_a (
        .clk(clk), .reset(rst_a), .enable(en_a), .mic_miso(miso_a),
        .mic_sclk(sclk_a), .mic_cs_n(csn_a), .sample(sample_a),
        .pcm(pcm_a), .sample_valid(valid_a), .frame_err(err_a)
    );

    logic [15:0] frame_a = 16'h0, cur_a = 16'h0;
    int          bi_a = 0;

    always @(negedge csn_a) begin
        cur_a = frame_a;
        bi_a  = 0;
    end

    always @(negedge sclk_a) begin
        if (!csn_a && bi_a < 16) begin
            miso_a = cur_a[15 - bi_a];
            bi_a++;
        end
    end

    int   low_a = 0, rise_a = 0, last_low_a = 0, last_rise_a = 0;
    int   nfall_a = 0, nvalid_a = 0, vt_a = 0;
    logic pcs_a = 1'b1, psclk_a = 1'b1, vcs_a = 1'b0, ve_a = 1'b0;
    logic [11:0] vs_a = 0, vp_a = 0;

    always @(negedge clk) begin
        cyc++;
        if (sclk_a && !psclk_a) rise_a++;
        if (!csn_a) begin
            if (pcs_a) begin
                low_a  = 0;
                rise_a = 0;
                nfall_a++;
            end
            low_a++;
        end else if (!pcs_a) begin
            last_low_a  = low_a;
            last_rise_a = rise_a;
        end
        if (valid_a) begin
            vs_a  = sample_a;
            vp_a  = pcm_a;
            ve_a  = err_a;
            vcs_a = csn_a;
            vt_a  = cyc;
            nvalid_a++;
        end
        pcs_a   = csn_a;
        psclk_a = sclk_a;
    end

    task automatic wait_valid_a(input string tag, input int budget);
        int  n0;
        logic ok;
        n0 = nvalid_a;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (nvalid_a != n0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_valid_seen"}, ok, 1'b1);
    endtask

    task automatic check_frame_a(input string tag, input logic [15:0] f);
        check({tag, "_sample"}, vs_a, m_sample(f));
        check({tag, "_pcm"}, vp_a, m_pcm(f));
        check({tag, "_err"}, ve_a, m_err(f));
        check({tag, "_cs_low"}, last_low_a, 32 * 13);
        check({tag, "_rises"}, last_rise_a, 16);
        check({tag, "_cs_at_valid"}, vcs_a, 1'b1);
    endtask

    task automatic wait_rise_a(input int n);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            if (!csn_a && rise_a == n) begin
                ok = 1'b1;
                break;
            end
        end
        check("reach_rise", ok, 1'b1);
    endtask

    // ---------------- DUT B: CLK_DIV=3, SAMPLE_PERIOD=100 ----------------
    logic        rst_b, en_b, miso_b = 1'b0;
    logic        sclk_b, csn_b, valid_b, err_b;
    logic [11:0] sample_b, pcm_b;

    mic3_receiver #(.CLK_DIV(3), .SAMPLE_PERIOD(100)) dut_b (
        .clk(clk), .reset(rst_b), .enable(en_b), .mic_miso(miso_b),
        .mic_sclk(sclk_b), .mic_cs_n(csn_b), .sample(sample_b),
        .pcm(pcm_b), .sample_valid(valid_b), .frame_err(err_b)
    );

    logic [15:0] cur_b = 16'h0;
    logic [15:0] exp_q[$];
    int          bi_b = 0;

    always @(negedge csn_b) begin
        cur_b = 16'($urandom);
        exp_q.push_back(cur_b);
        bi_b = 0;
    end

    always @(negedge sclk_b) begin
        if (!csn_b && bi_b < 16) begin
            miso_b = cur_b[15 - bi_b];
            bi_b++;
        end
    end

    int   low_b = 0, rise_b = 0, last_ev_b = 0, bad_b = 0;
    int   nvalid_b = 0, vt_b = 0;
    logic pcs_b = 1'b1, psclk_b = 1'b1;
    logic [15:0] ef;

    always @(negedge clk) begin
        if (sclk_b && !psclk_b) rise_b++;
        if (!csn_b && pcs_b) begin
            low_b     = 0;
            rise_b    = 0;
            last_ev_b = cyc;
        end
        if (!csn_b) low_b++;
        if ((!csn_b || !pcs_b) && sclk_b != psclk_b) begin
            if (cyc - last_ev_b != 3) bad_b++;
            last_ev_b = cyc;
        end
        if (valid_b) begin
            check("B_queue_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                ef = exp_q.pop_front();
                check("B_sample", sample_b, m_sample(ef));
                check("B_pcm", pcm_b, m_pcm(ef));
                check("B_err", err_b, m_err(ef));
            end
            check("B_cs_low", low_b, 96);
            check("B_rises", rise_b, 16);
            if (nvalid_b > 0) check("B_spacing", cyc - vt_b, 100);
            vt_b = cyc;
            nvalid_b++;
        end
        pcs_b   = csn_b;
        psclk_b = sclk_b;
    end

    // ---------------- stimulus ----------------
    int          t1, nf, nv;
    logic [15:0] f;
    logic        ok_b;

    initial begin
        rst_a = 1'b0;
        en_a  = 1'b0;
        rst_b = 1'b0;
        en_b  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", csn_a, 1'b1);
        check("rst_sclk", sclk_a, 1'b1);
        check("rst_sample", sample_a, 12'h000);
        check("rst_pcm", pcm_a, 12'h800);
        check("rst_err", err_a, 1'b0);
        check("rst_valid", valid_a, 1'b0);
        rst_a = 1'b1;
        rst_b = 1'b1;

        frame_a = 16'h0ABC;
        en_a    = 1'b1;
        wait_valid_a("f0ABC", 3000);
        check_frame_a("f0ABC", 16'h0ABC);
        @(negedge clk);
        check("valid_one_cycle", valid_a, 1'b0);

        frame_a = 16'h0800;
        wait_valid_a("f0800", 1500);
        check_frame_a("f0800", 16'h0800);
        t1      = vt_a;
        frame_a = 16'h07FF;
        wait_valid_a("f07FF", 1500);
        check_frame_a("f07FF", 16'h07FF);
        check("valid_spacing", vt_a - t1, 1000);

        frame_a = 16'h1FFF;
        wait_valid_a("f1FFF", 1500);
        check_frame_a("f1FFF", 16'h1FFF);
        frame_a = 16'h0000;
        wait_valid_a("f0000", 1500);
        check_frame_a("f0000", 16'h0000);

        for (int i = 0; i < 4; i++) begin
            f       = 16'($urandom);
            frame_a = f;
            wait_valid_a("rand", 1500);
            check_frame_a("rand", f);
        end

        f       = 16'($urandom);
        frame_a = f;
        wait_rise_a(8);
        en_a = 1'b0;
        wait_valid_a("dis", 1500);
        check_frame_a("dis", f);
        nf = nfall_a;
        repeat (2500) @(posedge clk);
        check("no_start_disabled", nfall_a, nf);
        t1      = vt_a;
        f       = 16'($urandom);
        frame_a = f;
        en_a    = 1'b1;
        wait_valid_a("reen", 2500);
        check_frame_a("reen", f);
        check("reen_aligned", (vt_a - t1) % 1000, 0);

        f       = 16'($urandom) | 16'h0001;
        frame_a = f;
        wait_rise_a(10);
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        check("arst_cs_n", csn_a, 1'b1);
        check("arst_sclk", sclk_a, 1'b1);
        check("arst_sample", sample_a, 12'h000);
        check("arst_pcm", pcm_a, 12'h800);
        check("arst_err", err_a, 1'b0);
        nv = nvalid_a;
        repeat (20) @(negedge clk);
        check("arst_no_valid", nvalid_a, nv);
        f       = 16'($urandom);
        frame_a = f;
        rst_a   = 1'b1;
        wait_valid_a("post_rst", 3000);
        check_frame_a("post_rst", f);
        en_a = 1'b0;

        en_b = 1'b1;
        ok_b = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            if (nvalid_b >= 30) begin
                ok_b = 1'b1;
                break;
            end
        end
        en_b = 1'b0;
        check("B_frames_seen", ok_b, 1'b1);
        check("B_halfperiod_bad", bad_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
